// File: rtl/read_add_vec_if.sv
// rtl/read_add_vec_if.sv - RAM port-0 set shared by the read-add engine and the RAM
interface read_add_vec_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] raddr_0;
    logic [DATA_WIDTH-1:0] rdata_0;
    logic [ADDR_WIDTH-1:0] waddr_0;
    logic                  wen_0;
    logic [DATA_WIDTH-1:0] wdata_0;

    modport master (
        output raddr_0,
        input  rdata_0,
        output waddr_0,
        output wen_0,
        output wdata_0
    );

    modport slave (
        input  raddr_0,
        output rdata_0,
        input  waddr_0,
        input  wen_0,
        input  wdata_0
    );
endinterface

// File: rtl/read_add_vec.sv
// rtl/read_add_vec.sv - vector read-add-write engine; READ_ADD_SAT_EN selects saturating add
module read_add_vec #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 8,
    parameter int ADD_LO     = 2,
    parameter int ADD_HI     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    output logic                  done,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic [1:0]            mode,
    read_add_vec_if.master        ram
`ifdef READ_ADD_SAT_EN
    ,
    output logic                  sat_hit
`endif
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  idx;
    logic [CNT_WIDTH:0]    idx_inc;
    logic [1:0]            mode_q;
    logic                  done_q;
    logic                  last;
    logic [DATA_WIDTH-1:0] addend;
    logic [DATA_WIDTH-1:0] sum;

    assign idx_inc = {1'b0, idx} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign last    = (idx_inc == {1'b0, cnt_q});

    always_comb begin
        addend = DATA_WIDTH'(ADD_LO);
        case (mode_q)
            2'd1:    addend = DATA_WIDTH'(ADD_HI);
            2'd2:    addend = ram.rdata_0[0] ? DATA_WIDTH'(ADD_HI) : DATA_WIDTH'(ADD_LO);
            default: addend = DATA_WIDTH'(ADD_LO);
        endcase
    end

`ifdef READ_ADD_SAT_EN
    logic [DATA_WIDTH:0] wide_sum;
    logic                clip;
    logic                sat_q;

    assign wide_sum = {1'b0, ram.rdata_0} + {1'b0, addend};
    assign clip     = wide_sum[DATA_WIDTH];
    assign sum      = clip ? {DATA_WIDTH{1'b1}} : wide_sum[DATA_WIDTH-1:0];
    assign sat_hit  = sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (state == IDLE && start) begin
            sat_q <= 1'b0;
        end else if (state == WR && clip) begin
            sat_q <= 1'b1;
        end
    end
`else
    assign sum = ram.rdata_0 + addend;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        ready       = (state == IDLE);
        done        = done_q;
        ram.raddr_0 = raddr_q;
        ram.wen_0   = 1'b0;
        ram.waddr_0 = '0;
        ram.wdata_0 = '0;
        case (state)
            IDLE: begin
                if (start && count != '0) begin
                    state_next = RD;
                end
            end
            RD: begin
                state_next = WR;
            end
            WR: begin
                ram.wen_0   = 1'b1;
                ram.waddr_0 = dst_q + ADDR_WIDTH'(idx);
                ram.wdata_0 = sum;
                state_next  = last ? IDLE : RD;
            end
            default: state_next = IDLE;
        endcase
    end

    // raddr is registered so it keeps its last value once the engine goes idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q   <= '0;
            dst_q   <= '0;
            raddr_q <= '0;
            cnt_q   <= '0;
            idx     <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        cnt_q  <= count;
                        mode_q <= mode;
                        idx    <= '0;
                        done_q <= (count == '0);
                        if (count != '0) begin
                            raddr_q <= src_addr;
                        end
                    end
                end
                WR: begin
                    idx <= idx_inc[CNT_WIDTH-1:0];
                    if (last) begin
                        done_q <= 1'b1;
                    end else begin
                        raddr_q <= src_q + ADDR_WIDTH'(idx_inc[CNT_WIDTH-1:0]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_read_add_vec.sv
// tb/tb_read_add_vec.sv - scoreboard bench for read_add_vec with a synchronous RAM model
module tb_read_add_vec;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic        done;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [7:0]  count;
    logic [1:0]  mode;
`ifdef READ_ADD_SAT_EN
    logic        sat_hit;
`endif

    logic [31:0] mem [0:255];
    wr_t         exp_q [$];
    wr_t         got;
    int          tests = 0;
    int          fails = 0;
    int          wen_seen = 0;

    read_add_vec_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ram_bus ();

    read_add_vec dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ready    (ready),
        .done     (done),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .count    (count),
        .mode     (mode),
        .ram      (ram_bus)
`ifdef READ_ADD_SAT_EN
        ,
        .sat_hit  (sat_hit)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_bus.rdata_0 <= mem[ram_bus.raddr_0[7:0]];
        if (ram_bus.wen_0) mem[ram_bus.waddr_0[7:0]] <= ram_bus.wdata_0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (ram_bus.wen_0) begin
            wen_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none",
                         ram_bus.waddr_0, ram_bus.wdata_0);
            end else begin
                got = exp_q.pop_front();
                check("wr_addr", ram_bus.waddr_0, got.addr);
                check("wr_data", ram_bus.wdata_0, got.data);
            end
        end
    end

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] d,
                       input logic [7:0] c, input logic [1:0] m);
        int n;
        int w0;
        @(negedge clk);
        src_addr = s; dst_addr = d; count = c; mode = m; start = 1'b1;
        w0 = wen_seen;
        @(posedge clk); #1;
        check("ready_after_start", {31'd0, ready}, {31'd0, c == 8'd0});
        check("done_after_start", {31'd0, done}, {31'd0, c == 8'd0});
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 600) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("done_latency", n, 2 * int'(c));
        check("ready_at_done", {31'd0, ready}, 32'd1);
        check("wen_pulses", wen_seen - w0, {24'd0, c});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        rst = 1'b1; start = 1'b0;
        src_addr = '0; dst_addr = '0; count = '0; mode = '0;
        #2;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wen", {31'd0, ram_bus.wen_0}, 32'd0);
        check("rst_raddr", ram_bus.raddr_0, 32'd0);
        check("rst_waddr", ram_bus.waddr_0, 32'd0);
        check("rst_wdata", ram_bus.wdata_0, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        mem[10] = 32'd15;
        expect_wr(32'd12, 32'd17);
        run(32'd10, 32'd12, 8'd1, 2'd0);
        check("t1_mem12", mem[12], 32'd17);

        mem[10] = 32'd1; mem[11] = 32'd2; mem[12] = 32'd3; mem[13] = 32'd4;
        expect_wr(32'd20, 32'd4); expect_wr(32'd21, 32'd4);
        expect_wr(32'd22, 32'd6); expect_wr(32'd23, 32'd6);
        run(32'd10, 32'd20, 8'd4, 2'd2);
        check("t2_mem20", mem[20], 32'd4);
        check("t2_mem23", mem[23], 32'd6);

        mem[30] = 32'd7; mem[31] = 32'd8;
        expect_wr(32'd30, 32'd10); expect_wr(32'd31, 32'd11);
        run(32'd30, 32'd30, 8'd2, 2'd1);
        check("t3_mem30", mem[30], 32'd10);
        check("t3_mem31", mem[31], 32'd11);

        run(32'd0, 32'd0, 8'd0, 2'd0);
        check("t4_done_sticky", {31'd0, done}, 32'd1);
        mem[60] = 32'd9;
        expect_wr(32'd61, 32'd11);
        run(32'd60, 32'd61, 8'd1, 2'd3);
        check("t4_mem61", mem[61], 32'd11);

        mem[5] = 32'hFFFF_FFFF;
`ifdef READ_ADD_SAT_EN
        expect_wr(32'd6, 32'hFFFF_FFFF);
        run(32'd5, 32'd6, 8'd1, 2'd1);
        check("t5_mem6", mem[6], 32'hFFFF_FFFF);
        check("t5_sat_hit", {31'd0, sat_hit}, 32'd1);
        mem[70] = 32'd1;
        expect_wr(32'd71, 32'd3);
        run(32'd70, 32'd71, 8'd1, 2'd0);
        check("t5_sat_cleared", {31'd0, sat_hit}, 32'd0);
`else
        expect_wr(32'd6, 32'd2);
        run(32'd5, 32'd6, 8'd1, 2'd1);
        check("t5_mem6", mem[6], 32'd2);
`endif

        // third element is mid-write when reset hits, so only two writes land
        for (int k = 0; k < 4; k++) begin
            mem[40 + k] = 32'd100 + 32'(k);
            mem[50 + k] = 32'hDEAD_0000 + 32'(k);
        end
        expect_wr(32'd50, 32'd102); expect_wr(32'd51, 32'd103);
        @(negedge clk);
        src_addr = 32'd40; dst_addr = 32'd50; count = 8'd4; mode = 2'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t6_wen_before_rst", {31'd0, ram_bus.wen_0}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_wen_async", {31'd0, ram_bus.wen_0}, 32'd0);
        check("t6_ready", {31'd0, ready}, 32'd1);
        check("t6_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("t6_mem50", mem[50], 32'd102);
        check("t6_mem51", mem[51], 32'd103);
        check("t6_mem52", mem[52], 32'hDEAD_0002);
        check("t6_mem53", mem[53], 32'hDEAD_0003);

        mem[80] = 32'd20; mem[81] = 32'd21;
        expect_wr(32'd90, 32'd23); expect_wr(32'd91, 32'd24);
        run(32'd80, 32'd90, 8'd2, 2'd1);
        check("t6_mem91", mem[91], 32'd24);

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
